// File: rtl/taxi_eth_addr_swap_pkg.sv
// taxi_eth_addr_swap_pkg: header length constants, FSM states and the emit-order helper.
package taxi_eth_addr_swap_pkg;

    localparam int HDR_LEN = 12;
    localparam int MAC_LEN = 6;

    typedef enum logic [1:0] {IDLE, CAP, EMIT, PASS} swap_state_t;

    // Maps an emit position to the buffered byte; swapping puts the source address first.
    function automatic logic [3:0] swap_idx(input logic [3:0] idx, input logic swap);
        if (!swap) return idx;
        return idx < 4'(MAC_LEN) ? idx + 4'(MAC_LEN) : idx - 4'(MAC_LEN);
    endfunction

endpackage

// File: rtl/taxi_eth_addr_swap_if.sv
// taxi_axis_if: AXI4-Stream bundle with src/snk modports.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) ();

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);

endinterface

// File: rtl/taxi_eth_addr_swap.sv
// taxi_eth_addr_swap: buffers the 12-byte MAC header, re-emits it with dst/src swapped, then passes the frame through.
module taxi_eth_addr_swap
    import taxi_eth_addr_swap_pkg::*;
#(
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    taxi_axis_if.snk    s_axis,
    taxi_axis_if.src    m_axis,
    input  logic        cfg_swap_en,
    output logic        stat_frame,
    output logic        stat_runt
);

    swap_state_t       state_q, state_d;
    logic [7:0]        hdr_q [HDR_LEN];
    logic [7:0]        hdr_d [HDR_LEN];
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        len_q, len_d;
    logic              swap_q, swap_d;
    logic              runt_q, runt_d;
    logic              hlast_q, hlast_d;
    logic [USER_W-1:0] huser_q, huser_d;
    logic [ID_W-1:0]   tid_q, tid_d;
    logic [7:0]        m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic              m_runt_q, m_runt_d;
    logic [USER_W-1:0] m_tuser_q, m_tuser_d;
    logic [ID_W-1:0]   m_tid_q, m_tid_d;
    logic              load;
    logic              s_fire;
    logic              emit_last;

    assign load          = !m_tvalid_q || m_axis.tready;
    assign s_axis.tready = !rst && (state_q == IDLE || state_q == CAP || (state_q == PASS && load));
    assign s_fire        = s_axis.tvalid && s_axis.tready;
    assign emit_last     = cnt_q == len_q - 4'd1;

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = '1;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tid    = m_tid_q;
    assign m_axis.tuser  = m_tuser_q;
    assign stat_frame    = m_tvalid_q && m_axis.tready && m_tlast_q;
    assign stat_runt     = stat_frame && m_runt_q;

    always_ff @(posedge clk) begin
        hdr_q     <= hdr_d;
        tid_q     <= tid_d;
        huser_q   <= huser_d;
        m_tdata_q <= m_tdata_d;
        m_tid_q   <= m_tid_d;
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            swap_q     <= 1'b0;
            runt_q     <= 1'b0;
            hlast_q    <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_runt_q   <= 1'b0;
            m_tuser_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            swap_q     <= swap_d;
            runt_q     <= runt_d;
            hlast_q    <= hlast_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_runt_q   <= m_runt_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = s_fire ? (s_axis.tlast ? EMIT : CAP) : IDLE;
            CAP:     state_d = s_fire && (s_axis.tlast || cnt_q == 4'(HDR_LEN - 1)) ? EMIT : CAP;
            EMIT:    state_d = !(load && emit_last) ? EMIT : (runt_q || hlast_q) ? IDLE : PASS;
            default: state_d = s_fire && s_axis.tlast ? IDLE : PASS;
        endcase
    end

    // A frame ending inside the header is a runt: emitted in arrival order, flagged bad on its last byte.
    always_comb begin
        hdr_d      = hdr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        swap_d     = swap_q;
        runt_d     = runt_q;
        hlast_d    = hlast_q;
        huser_d    = huser_q;
        tid_d      = tid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_runt_d   = m_runt_q;
        m_tuser_d  = m_tuser_q;
        m_tid_d    = m_tid_q;
        m_tvalid_d = m_tvalid_q && !m_axis.tready;
        if (state_q == IDLE && s_fire) begin
            hdr_d[0] = s_axis.tdata;
            tid_d    = s_axis.tid;
            swap_d   = cfg_swap_en;
            runt_d   = s_axis.tlast;
            len_d    = s_axis.tlast ? 4'd1 : 4'(HDR_LEN);
            hlast_d  = 1'b0;
            huser_d  = '0;
            cnt_d    = s_axis.tlast ? 4'd0 : 4'd1;
        end
        if (state_q == CAP && s_fire) begin
            hdr_d[cnt_q] = s_axis.tdata;
            cnt_d        = (s_axis.tlast || cnt_q == 4'(HDR_LEN - 1)) ? 4'd0 : cnt_q + 4'd1;
            runt_d       = s_axis.tlast && cnt_q != 4'(HDR_LEN - 1);
            len_d        = runt_d ? cnt_q + 4'd1 : 4'(HDR_LEN);
            hlast_d      = s_axis.tlast;
            huser_d      = s_axis.tuser;
        end
        if (state_q == EMIT && load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = hdr_q[swap_idx(cnt_q, swap_q && !runt_q)];
            m_tid_d    = tid_q;
            m_tlast_d  = emit_last && (runt_q || hlast_q);
            m_runt_d   = emit_last && runt_q;
            m_tuser_d  = !emit_last ? '0 : runt_q ? USER_W'(1) : hlast_q ? huser_q : '0;
            cnt_d      = cnt_q + 4'd1;
        end
        if (state_q == PASS && s_fire) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis.tdata;
            m_tid_d    = s_axis.tid;
            m_tlast_d  = s_axis.tlast;
            m_tuser_d  = s_axis.tuser;
            m_runt_d   = 1'b0;
        end
    end

endmodule
